// File: rtl/multiplier_nbit_iter.sv
// ---------------------------------------------------------------------------
// multiplier_nbit_iter
//   Iterative shift-add multiplier producing the low NBITS bits of in0*in1.
//   The result is correct for both signed and unsigned operands.
//   Operands and product move over val/rdy streams. Only one operation is in
//   flight at a time.
//
//   Optional feature macro: MULT_EARLY_EXIT_EN
//     When defined, the calculation stops as soon as the remaining multiplier
//     bits are all zero. The result is the same either way.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   istream_val  in   1      operands valid
//   istream_rdy  out  1      block can accept operands (IDLE)
//   in0          in   NBITS  multiplicand
//   in1          in   NBITS  multiplier
//   ostream_val  out  1      product valid (DONE)
//   ostream_rdy  in   1      consumer accepts product
//   prod         out  NBITS  low NBITS bits of in0*in1
// ---------------------------------------------------------------------------
module multiplier_nbit_iter #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [NBITS-1:0] prod
);

  localparam int unsigned CW = $clog2(NBITS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic [NBITS-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] b_shift_c;
  logic             last_c;

  assign b_shift_c = b >> 1;

  // Final CALC iteration: bit count exhausted, or (optionally) no multiplier bits left
  always_comb begin
    last_c = (cnt == CW'(NBITS - 1));
`ifdef MULT_EARLY_EXIT_EN
    if (b_shift_c == '0) begin
      last_c = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (istream_val)  state_nxt = CALC;
      CALC:    if (last_c)       state_nxt = DONE;
      DONE:    if (ostream_rdy)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output decode; prod comes straight from the accumulator register
  always_comb begin
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    prod        = acc;
    case (state)
      IDLE:    istream_rdy = 1'b1;
      DONE:    ostream_val = 1'b1;
      default: ;
    endcase
  end

  // Shift-add datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            a   <= in0;
            b   <= in1;
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          if (b[0]) begin
            acc <= acc + a;
          end
          a   <= a << 1;
          b   <= b_shift_c;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
